// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PARITY_IDX = 9;
    localparam int unsigned STOP_IDX   = 10;
    localparam int unsigned BIT_CNT_W  = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } ps2_state_e;

    // Odd parity over data plus parity bit.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clock_filter.sv
// Deglitches the synchronized PS/2 clock and emits a one-cycle strobe
// in the first cycle the filtered clock reads low.
module ps2_clock_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_i,
    output logic strobe_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_q, strobe_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    // Flip only after FILTER_LEN consecutive disagreeing cycles.
    always_comb begin
        filt_d   = filt_q;
        cnt_d    = '0;
        strobe_d = 1'b0;
        if (ps2_clk_i != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d   = ps2_clk_i;
                strobe_d = filt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame decoder: start/data/parity/stop checking,
// inter-edge timeout, single-byte holding register with valid/ready.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ps2ClockSync,
    input  logic                 ps2DataSync,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 parityError,
    output logic                 frameError,
    output logic                 overrun
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic strobe;

    ps2_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    ps2_clock_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clock_filter (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk_i (ps2ClockSync),
        .strobe_o  (strobe)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && dataReady) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (strobe) begin
                    if (!ps2DataSync) begin
                        state_d   = ST_RECEIVE;
                        bit_cnt_d = BIT_CNT_W'(1);
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            ST_RECEIVE: begin
                if (strobe) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(STOP_IDX)) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        if (!ps2DataSync) begin
                            ferr_d = 1'b1;
                        end else if (!odd_parity_ok(shift_q, parity_q)) begin
                            perr_d = 1'b1;
                        end else if (!valid_q || dataReady) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else if (bit_cnt_q == BIT_CNT_W'(PARITY_IDX)) begin
                        parity_d = ps2DataSync;
                    end else begin
                        shift_d = {ps2DataSync, shift_q[DATA_BITS-1:1]};
                    end
                end else if (tmo_q >= TMO_W'(TIMEOUT_CYCLES)) begin
                    // Stalled device: drop the partial frame.
                    ferr_d    = 1'b1;
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dataOut     = data_q;
    assign dataValid   = valid_q;
    assign parityError = perr_q;
    assign frameError  = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: bytes queued at send time, popped on delivery.
module tb_ps2_frame_receiver;

    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 200;
    localparam int unsigned HALF       = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;

    int n_checks = 0;
    int n_fails  = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic prev_perr = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_ovr  = 1'b0;
    logic [7:0] exp_q[$];

    ps2_frame_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .ps2ClockSync (ps2_clk),
        .ps2DataSync  (ps2_dat),
        .dataOut      (data_out),
        .dataValid    (data_valid),
        .dataReady    (data_ready),
        .parityError  (parity_error),
        .frameError   (frame_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // One clock step; scores deliveries and counts error pulses.
    task automatic tick();
        logic v_before;
        logic r_before;
        logic [7:0] exp;
        v_before = data_valid;
        r_before = data_ready;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (data_valid && (!v_before || r_before)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL delivery: unexpected byte %02h, none queued", data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (data_out !== exp) begin
                        n_fails++;
                        $display("FAIL delivery: dataOut=%02h expected %02h", data_out, exp);
                    end
                end
            end
            if (parity_error) perr_cnt++;
            if (frame_error)  ferr_cnt++;
            if (overrun)      ovr_cnt++;
            if ((parity_error && prev_perr) || (frame_error && prev_ferr) || (overrun && prev_ovr)) begin
                n_checks++;
                n_fails++;
                $display("FAIL pulse_width: error pulse longer than 1 cycle (p=%b f=%b o=%b)",
                         parity_error, frame_error, overrun);
            end
        end
        prev_perr = parity_error;
        prev_ferr = frame_error;
        prev_ovr  = overrun;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Drive the first nbits of a frame; optional latency check or ready pulse on the stop strobe.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit lat_chk,
                             input logic [7:0] lat_exp, input bit rdy_pulse);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) tick();
            ps2_clk = 1'b0;
            if (i == 10 && (lat_chk || rdy_pulse)) begin
                repeat (FILTER_LEN) tick();
                if (rdy_pulse) data_ready = 1'b1;
                if (lat_chk) begin
                    n_checks++;
                    if (data_valid !== 1'b0) begin
                        n_fails++;
                        $display("FAIL latency_early: dataValid=%b expected 0", data_valid);
                    end
                end
                tick();
                if (rdy_pulse) data_ready = 1'b0;
                if (lat_chk) begin
                    n_checks++;
                    if (data_valid !== 1'b1 || data_out !== lat_exp) begin
                        n_fails++;
                        $display("FAIL latency: dataValid=%b dataOut=%02h expected 1/%02h",
                                 data_valid, data_out, lat_exp);
                    end
                end
                repeat (HALF - FILTER_LEN - 1) tick();
            end else begin
                repeat (HALF) tick();
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) tick();
    endtask

    task automatic check_errs(input string name, input int p, input int f, input int o);
        n_checks++;
        if (perr_cnt !== p || ferr_cnt !== f || ovr_cnt !== o) begin
            n_fails++;
            $display("FAIL %s: err counts p/f/o=%0d/%0d/%0d expected %0d/%0d/%0d",
                     name, perr_cnt, ferr_cnt, ovr_cnt, p, f, o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || parity_error !== 1'b0 ||
            frame_error !== 1'b0 || overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL reset: out=%02h v=%b p=%b f=%b o=%b expected 00/0/0/0/0",
                     data_out, data_valid, parity_error, frame_error, overrun);
        end
        rst_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_good_frame();
        exp_q.push_back(8'h1C);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b1, 8'h1C, 1'b0);
        check_errs("good_frame_errs", 0, 0, 0);
    endtask

    task automatic test_parity_error();
        send_bits(make_frame(8'hF0, 1'b1, 1'b1), 11, 1'b0, 8'h00, 1'b0);
        check_errs("parity_errs", 1, 0, 0);
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL parity_valid: dataValid=%b expected 0", data_valid);
        end
    endtask

    task automatic test_timeout();
        send_bits(make_frame(8'h77, 1'b0, 1'b1), 4, 1'b0, 8'h00, 1'b0);
        repeat (TIMEOUT + 50) tick();
        check_errs("timeout_errs", 1, 1, 0);
        exp_q.push_back(8'h5A);
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, 1'b0, 8'h00, 1'b0);
        check_errs("after_timeout_errs", 1, 1, 0);
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_bits(make_frame(8'h11, 1'b0, 1'b1), 11, 1'b0, 8'h00, 1'b0);
        send_bits(make_frame(8'h22, 1'b0, 1'b1), 11, 1'b0, 8'h00, 1'b0);
        check_errs("overrun_errs", 1, 1, 1);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h11) begin
            n_fails++;
            $display("FAIL overrun_hold: v=%b out=%02h expected 1/11", data_valid, data_out);
        end
        exp_q.push_back(8'h33);
        send_bits(make_frame(8'h33, 1'b0, 1'b1), 11, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h33) begin
            n_fails++;
            $display("FAIL consume_load: v=%b out=%02h expected 1/33", data_valid, data_out);
        end
        check_errs("consume_load_errs", 1, 1, 1);
        data_ready = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== 8'h33) begin
            n_fails++;
            $display("FAIL drain: v=%b out=%02h expected 0/33", data_valid, data_out);
        end
    endtask

    task automatic test_glitch_and_stop();
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) tick();
        ps2_clk = 1'b1;
        repeat (HALF) tick();
        check_errs("glitch_errs", 1, 1, 1);
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL glitch_valid: dataValid=%b expected 0", data_valid);
        end
        send_bits(make_frame(8'h3C, 1'b1, 1'b0), 11, 1'b0, 8'h00, 1'b0);
        check_errs("bad_stop_errs", 1, 2, 1);
    endtask

    task automatic test_mid_reset();
        send_bits(make_frame(8'h0F, 1'b0, 1'b1), 5, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || parity_error !== 1'b0 ||
            frame_error !== 1'b0 || overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset: out=%02h v=%b p=%b f=%b o=%b expected 00/0/0/0/0",
                     data_out, data_valid, parity_error, frame_error, overrun);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        exp_q.push_back(8'hAA);
        send_bits(make_frame(8'hAA, 1'b0, 1'b1), 11, 1'b0, 8'h00, 1'b0);
        check_errs("after_reset_errs", 1, 2, 1);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_timeout();
        test_overrun();
        test_glitch_and_stop();
        test_mid_reset();
        repeat (10) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d bytes never delivered, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
